// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Handshake and operand/result bundle for the bit-serial subtractor.
//   master: drives start, a, b; observes busy, done, diff, bout (and ovf).
//   slave : the subtractor itself.
// Signals:
//   start        request, sampled by the subtractor only while idle
//   a, b         minuend / subtrahend, captured on an accepted start
//   busy         high while bits are being shifted through
//   done         one-cycle pulse; diff/bout valid from this cycle onward
//   diff         a - b modulo 2**WIDTH
//   bout         final borrow (1 iff a < b, unsigned)
//   ovf          signed overflow, present only when SERIAL_SUB_OVF_EN is defined
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b,
    input  busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, bout
`ifdef SERIAL_SUB_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial WIDTH-bit subtractor. Operands are captured on an accepted
//   start, then one difference bit per clock is produced LSB first through a
//   full-subtractor cell. Result and final borrow hold until the next start.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    serial_subtractor_if.slave (start, a, b, busy, done, diff, bout[, ovf])
// Parameter:
//   WIDTH  operand/result width, 2..32; must match the interface WIDTH
// Build option:
//   SERIAL_SUB_OVF_EN  adds the signed-overflow output ovf
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] diff_q;
  logic             borrow;
  logic             bout_q;
  logic [CNT_W-1:0] cnt;
  logic             d;
  logic             bo;
  logic             last;
  logic             busy;
  logic             done;

  // Full-subtractor cell: returns {difference, borrow_out}.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
    logic dd;
    logic bb;
    dd = x ^ y ^ bi;
    bb = (~x & y) | (~(x ^ y) & bi);
    return {dd, bb};
  endfunction

  assign {d, bo} = full_sub(sa[0], sb[0], borrow);
  assign last    = (cnt == LAST_BIT);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath. Operands shift right so the current bit is always at [0];
  // each difference bit enters at the MSB so bit 0 lands at diff[0] after
  // WIDTH shifts. cnt reaches WIDTH on the final shift, which CNT_W holds.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa     <= '0;
      sb     <= '0;
      diff_q <= '0;
      borrow <= 1'b0;
      bout_q <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sa     <= bus.a;
            sb     <= bus.b;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          diff_q <= {d, diff_q[WIDTH-1:1]};
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= bo;
          cnt    <= cnt + 1'b1;
          if (last) bout_q <= bo;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic ovf_q;

  // On the last bit sa[0]/sb[0] are the captured operand MSBs and d is the
  // result MSB: overflow when operand signs differ and the result sign
  // differs from the minuend.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == SHIFT && last) begin
      ovf_q <= (sa[0] != sb[0]) && (d != sa[0]);
    end
  end

  assign bus.ovf = ovf_q;
`endif

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed and randomized checks of serial_subtractor (WIDTH=8) against an
//   arithmetic reference: diff = (a-b) mod 256, bout = a<b, ovf from signed
//   range of a-b.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] last_diff;

  // One transaction: waits for idle, issues start, counts edges to done and
  // compares the result with plain arithmetic. With hold set, start stays high
  // and a/b are scrambled during the shift; the result must ignore that.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_op, input bit hold);
    int           k;
    int           guard;
    int           sres;
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    ed   = ta - tb_op;
    eb   = (ta < tb_op);
    sres = int'($signed(ta)) - int'($signed(tb_op));
    eo   = (sres > 127) || (sres < -128);
    guard = 0;
    @(negedge clk);
    while ((bus.busy || bus.done) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b1;
    bus.a     = ta;
    bus.b     = tb_op;
    @(posedge clk);
    #1;
    check("busy_after_start", 32'(bus.busy), 32'd1);
    if (!hold) bus.start = 1'b0;
    k = 0;
    while (!bus.done && k < 3 * W) begin
      if (hold) begin
        bus.a = W'($urandom);
        bus.b = W'($urandom);
      end
      @(posedge clk);
      #1;
      k++;
    end
    if (hold) bus.start = 1'b0;
    check("latency", 32'(k), 32'(W));
    check("diff", 32'(bus.diff), 32'(ed));
    check("bout", 32'(bus.bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check("ovf", 32'(bus.ovf), 32'(eo));
`else
    eo = 1'b0;
`endif
    last_diff = ed;
  endtask

  // done must be a single-cycle pulse and diff must hold afterwards.
  task automatic check_hold();
    @(posedge clk);
    #1;
    check("done_pulse", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    check("diff_hold", 32'(bus.diff), 32'(last_diff));
  endtask

  initial begin
    bit seen;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    last_diff = '0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h05, 8'h03, 1'b0);
    check_hold();
    run_op(8'h03, 8'h05, 1'b0);
    check_hold();
    run_op(8'h00, 8'hFF, 1'b0);
    run_op(8'hA5, 8'hA5, 1'b0);
    run_op(8'h11, 8'h22, 1'b1);
    check_hold();
`ifdef SERIAL_SUB_OVF_EN
    run_op(8'h80, 8'h01, 1'b0);
    run_op(8'h7F, 8'h01, 1'b0);
`endif

    // Reset in the middle of a shift: no done, outputs cleared.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h5A;
    bus.b     = 8'h33;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_diff", 32'(bus.diff), 32'd0);
    check("midrst_bout", 32'(bus.bout), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run_op(8'hC3, 8'h3C, 1'b0);

    // Back-to-back random operations.
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
